// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, load-use stall, ALU and EX/MEM output register.
// Optional signed-overflow trap is built when EXE_OVERFLOW_TRAP_EN is defined.

module alu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ALU_OP_LEN = 4
) (
  input  logic [ALU_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      result
);
  localparam int unsigned SHW = $clog2(WIDTH);

  // Operation encodings mirror common.vh
  localparam logic [ALU_OP_LEN-1:0] ALU_ADD  = ALU_OP_LEN'(0);
  localparam logic [ALU_OP_LEN-1:0] ALU_SUB  = ALU_OP_LEN'(1);
  localparam logic [ALU_OP_LEN-1:0] ALU_AND  = ALU_OP_LEN'(2);
  localparam logic [ALU_OP_LEN-1:0] ALU_OR   = ALU_OP_LEN'(3);
  localparam logic [ALU_OP_LEN-1:0] ALU_XOR  = ALU_OP_LEN'(4);
  localparam logic [ALU_OP_LEN-1:0] ALU_SLL  = ALU_OP_LEN'(5);
  localparam logic [ALU_OP_LEN-1:0] ALU_SRL  = ALU_OP_LEN'(6);
  localparam logic [ALU_OP_LEN-1:0] ALU_SRA  = ALU_OP_LEN'(7);
  localparam logic [ALU_OP_LEN-1:0] ALU_SLT  = ALU_OP_LEN'(8);
  localparam logic [ALU_OP_LEN-1:0] ALU_SLTU = ALU_OP_LEN'(9);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = WIDTH'($signed(a) >>> shamt);
      ALU_SLT:  result = WIDTH'(lt_s);
      ALU_SLTU: result = WIDTH'(lt_u);
      default:  result = '0;
    endcase
  end
endmodule

module exe_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_LEN-1:0] in_alu_op,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [WIDTH-1:0]      in_rs1_val,
  input  logic [WIDTH-1:0]      in_rs2_val,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic                  in_ov_check,
  input  logic                  wb_fwd_en,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [WIDTH-1:0]      wb_fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [WIDTH-1:0]      out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  output logic                  out_is_load,
  output logic                  out_exc
);
  localparam logic [ALU_OP_LEN-1:0] ALU_ADD = ALU_OP_LEN'(0);
  localparam logic [ALU_OP_LEN-1:0] ALU_SUB = ALU_OP_LEN'(1);

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_result_q, out_result_d;
  logic [WIDTH-1:0]      out_store_data_q, out_store_data_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_wen_q, out_wen_d;
  logic                  out_is_load_q, out_is_load_d;
  logic                  out_exc_q, out_exc_d;

  logic             own_fwd;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             hazard;
  logic             advance;
  logic             take;
  logic             ovf;

  // Loads are not forwarded from the output register; their data is not known yet
  assign own_fwd = out_valid_q && out_wen_q && !out_is_load_q;

  always_comb begin
    if (in_rs1 == '0)                               fwd_rs1 = '0;
    else if (own_fwd && (out_rd_q == in_rs1))       fwd_rs1 = out_result_q;
    else if (wb_fwd_en && (wb_fwd_rd == in_rs1))    fwd_rs1 = wb_fwd_data;
    else                                            fwd_rs1 = in_rs1_val;
  end

  always_comb begin
    if (in_rs2 == '0)                               fwd_rs2 = '0;
    else if (own_fwd && (out_rd_q == in_rs2))       fwd_rs2 = out_result_q;
    else if (wb_fwd_en && (wb_fwd_rd == in_rs2))    fwd_rs2 = wb_fwd_data;
    else                                            fwd_rs2 = in_rs2_val;
  end

  assign op_b = in_use_imm ? in_imm : fwd_rs2;

  alu #(
    .WIDTH      (WIDTH),
    .ALU_OP_LEN (ALU_OP_LEN)
  ) u_alu (
    .op     (in_alu_op),
    .a      (fwd_rs1),
    .b      (op_b),
    .result (alu_res)
  );

  // Stores (wen=0) always consume rs2 even though B is the immediate
  assign hazard = in_valid && out_valid_q && out_is_load_q && out_wen_q && (out_rd_q != '0) &&
                  ((out_rd_q == in_rs1) ||
                   ((!in_use_imm || !in_wen) && (out_rd_q == in_rs2)));

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = flush || (advance && !hazard);
  assign take     = in_valid && !hazard;

`ifdef EXE_OVERFLOW_TRAP_EN
  logic sa, sb, sr;
  assign sa  = fwd_rs1[WIDTH-1];
  assign sb  = op_b[WIDTH-1];
  assign sr  = alu_res[WIDTH-1];
  assign ovf = in_ov_check &&
               (((in_alu_op == ALU_ADD) && (sa == sb) && (sr != sa)) ||
                ((in_alu_op == ALU_SUB) && (sa != sb) && (sr != sa)));
`else
  logic unused_ov_check;
  logic [ALU_OP_LEN-1:0] unused_ops;
  assign unused_ov_check = in_ov_check;
  assign unused_ops      = ALU_ADD ^ ALU_SUB;
  assign ovf             = 1'b0;
`endif

  // Flush beats everything, including a stalled output
  always_comb begin
    out_valid_d      = out_valid_q;
    out_result_d     = out_result_q;
    out_store_data_d = out_store_data_q;
    out_rd_d         = out_rd_q;
    out_wen_d        = out_wen_q;
    out_is_load_d    = out_is_load_q;
    out_exc_d        = out_exc_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_wen_d   = 1'b0;
      out_exc_d   = 1'b0;
    end else if (advance) begin
      out_valid_d = take;
      if (take) begin
        out_result_d     = alu_res;
        out_store_data_d = fwd_rs2;
        out_rd_d         = in_rd;
        out_wen_d        = in_wen && !ovf;
        out_is_load_d    = in_is_load;
        out_exc_d        = ovf;
      end else begin
        out_wen_d = 1'b0;
        out_exc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_store_data_q <= '0;
      out_rd_q         <= '0;
      out_wen_q        <= 1'b0;
      out_is_load_q    <= 1'b0;
      out_exc_q        <= 1'b0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_store_data_q <= out_store_data_d;
      out_rd_q         <= out_rd_d;
      out_wen_q        <= out_wen_d;
      out_is_load_q    <= out_is_load_d;
      out_exc_q        <= out_exc_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_store_data_q;
  assign out_rd         = out_rd_q;
  assign out_wen        = out_wen_q;
  assign out_is_load    = out_is_load_q;
  assign out_exc        = out_exc_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: forwarding, load-use stall, back-pressure, overflow, flush, reset.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_use_imm, in_wen, in_is_load, in_ov_check;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_wen, out_is_load, out_exc;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_load(in_is_load), .in_ov_check(in_ov_check),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_wen(out_wen),
    .out_is_load(out_is_load), .out_exc(out_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] r1v, input logic [31:0] r2v, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic ov);
    in_valid = v; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rs1_val = r1v; in_rs2_val = r2v; in_imm = imm; in_use_imm = ui;
    in_rd = rd; in_wen = wen; in_is_load = ld; in_ov_check = ov;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_fwd_en = en; wb_fwd_rd = rd; wb_fwd_data = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_wen"},   32'(out_wen), 32'd0);
    chk({tag, "_load"},  32'(out_is_load), 32'd0);
    chk({tag, "_exc"},   32'(out_exc), 32'd0);
    chk({tag, "_res"},   out_result, 32'd0);
    chk({tag, "_sd"},    out_store_data, 32'd0);
    chk({tag, "_rd"},    32'(out_rd), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    #12;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // x1 = 5 (wb fwd of x10) + 7, then x2 = x1 + 1 through own-output forwarding
    drive(1'b1, ADD, 5'd10, 5'd0, 32'd0, 32'd0, 32'd7, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd10, 32'd5);
    #1 chk("b2b_rdy0", 32'(in_ready), 32'd1);
    cycle();
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_r1", out_result, 32'd12);
    chk("b2b_rd1", 32'(out_rd), 32'd1);
    drive(1'b1, ADD, 5'd1, 5'd0, 32'd0, 32'd0, 32'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1 chk("b2b_rdy1", 32'(in_ready), 32'd1);
    cycle();
    chk("b2b_v2", 32'(out_valid), 32'd1);
    chk("b2b_r2", out_result, 32'd13);

    // x4 = x2(own, 13) - x1(wb, 12); store data is forwarded rs2
    drive(1'b1, SUB, 5'd2, 5'd1, 32'd0, 32'd0, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd1, 32'd12);
    cycle();
    chk("sub_res", out_result, 32'd1);
    chk("sub_sd", out_store_data, 32'd12);
    // own output beats wb and rf for both operands: 1 + 1
    drive(1'b1, ADD, 5'd4, 5'd4, 32'h55, 32'h55, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd4, 32'h99);
    cycle();
    chk("prio_res", out_result, 32'd2);

    // Load-use: load x3, then ADD x6 = x3 + 2
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h100, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    cycle();
    chk("ld_load", 32'(out_is_load), 32'd1);
    chk("ld_addr", out_result, 32'h100);
    drive(1'b1, ADD, 5'd3, 5'd0, 32'd0, 32'd0, 32'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd3, 32'h40);
    #1 chk("lu_stall", 32'(in_ready), 32'd0);
    cycle();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_rdy", 32'(in_ready), 32'd1);
    cycle();
    chk("lu_v", 32'(out_valid), 32'd1);
    chk("lu_res", out_result, 32'h42);
    chk("lu_rd", 32'(out_rd), 32'd6);

    // Store after load into its data register also stalls
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h200, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    cycle();
    drive(1'b1, ADD, 5'd0, 5'd3, 32'd0, 32'd0, 32'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd3, 32'h40);
    #1 chk("st_stall", 32'(in_ready), 32'd0);
    cycle();
    chk("st_bubble", 32'(out_valid), 32'd0);
    cycle();
    chk("st_addr", out_result, 32'd8);
    chk("st_data", out_store_data, 32'h40);
    chk("st_wen", 32'(out_wen), 32'd0);

    // x0 operand reads 0 even with wb forwarding to x0
    drive(1'b1, ADD, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd0, 32'h77);
    cycle();
    chk("x0_res", out_result, 32'd3);

    // Back-pressure for 3 cycles
    out_ready = 1'b0;
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h20, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1 chk("bp_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_v", 32'(out_valid), 32'd1);
      chk("bp_res", out_result, 32'd3);
      chk("bp_rd", 32'(out_rd), 32'd7);
      chk("bp_rdy_h", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel", 32'(in_ready), 32'd1);
    cycle();
    chk("bp_b1", out_result, 32'h20);
    chk("bp_b1rd", 32'(out_rd), 32'd8);
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h21, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bp_b2", out_result, 32'h21);
    chk("bp_b2rd", 32'(out_rd), 32'd9);

    // Signed overflow on checked ADD and SUB, and unchecked ADD
    drive(1'b1, ADD, 5'd11, 5'd0, 32'h7FFFFFFF, 32'd0, 32'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("ov_res", out_result, 32'h80000000);
`ifdef EXE_OVERFLOW_TRAP_EN
    chk("ov_exc", 32'(out_exc), 32'd1);
    chk("ov_wen", 32'(out_wen), 32'd0);
`else
    chk("ov_exc", 32'(out_exc), 32'd0);
    chk("ov_wen", 32'(out_wen), 32'd1);
`endif
    drive(1'b1, ADD, 5'd11, 5'd0, 32'h7FFFFFFF, 32'd0, 32'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("nov_res", out_result, 32'h80000000);
    chk("nov_exc", 32'(out_exc), 32'd0);
    chk("nov_wen", 32'(out_wen), 32'd1);
    drive(1'b1, SUB, 5'd11, 5'd0, 32'h80000000, 32'd0, 32'd1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("sov_res", out_result, 32'h7FFFFFFF);
`ifdef EXE_OVERFLOW_TRAP_EN
    chk("sov_exc", 32'(out_exc), 32'd1);
`else
    chk("sov_exc", 32'(out_exc), 32'd0);
`endif

    // Flush while stalled: output invalidated, input beat dropped
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h55, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    #1 chk("fl_rdy", 32'(in_ready), 32'd1);
    cycle();
    chk("fl_v", 32'(out_valid), 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("fl_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges
    drive(1'b1, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'h66, 1'b1, 5'd14, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("ar_pre", 32'(out_valid), 32'd1);
    drive(1'b0, ADD, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    rst_n = 1'b1;
    cycle();
    chk("ar_post", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
